// File: rtl/inst_axi_rd_bridge.sv
// Instruction-side SRAM-like to AXI read bridge: one AR per accepted fetch,
// in-order R return with a bounded outstanding count and a sticky error flag.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   inst_sram_*              fetch-side request/response (req/addr_ok/data_ok)
//   axi_arid                 current ARID exported to IF
//   ar*/arvalid/arready      AXI read address channel (single-beat INCR)
//   r*/rvalid/rready         AXI read data channel
//   err_sticky               write request or non-OKAY rresp seen since reset
module inst_axi_rd_bridge #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [3:0]  ARID_VAL        = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    output logic [3:0]  axi_arid,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        err_sticky
);

    typedef enum logic {
        AR_IDLE,
        AR_BUSY
    } ar_state_e;

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    ar_state_e  state;
    ar_state_e  state_nxt;
    logic       latch_en;
    logic [2:0] out_cnt;
    logic       ar_hs;
    logic       r_acc;

    // Write-side inputs and rlast carry no information for a single-beat reader.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_wstrb, inst_sram_wdata, rlast};

    assign ar_hs = arvalid & arready;
    assign r_acc = rvalid & rready & (rid == ARID_VAL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= AR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        unique case (state)
            AR_IDLE: begin
                if (inst_sram_req & ~inst_sram_wr & (out_cnt < MAX_CNT)) begin
                    latch_en  = 1'b1;
                    state_nxt = AR_BUSY;
                end
            end
            AR_BUSY: begin
                if (arready) begin
                    state_nxt = AR_IDLE;
                end
            end
            default: state_nxt = AR_IDLE;
        endcase
    end

    // Address and size are captured once; later requester changes are ignored
    // until the handshake frees the channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr <= 32'h0;
            arsize <= 3'b000;
        end else if (latch_en) begin
            araddr <= inst_sram_addr;
            arsize <= {1'b0, inst_sram_size};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_cnt <= 3'd0;
        end else begin
            unique case ({ar_hs, r_acc})
                2'b10: if (out_cnt != 3'd7) out_cnt <= out_cnt + 3'd1;
                2'b01: if (out_cnt != 3'd0) out_cnt <= out_cnt - 3'd1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if ((inst_sram_req & inst_sram_wr) | (r_acc & (rresp != 2'b00))) begin
            err_sticky <= 1'b1;
        end
    end

    assign arvalid           = (state == AR_BUSY);
    assign rready            = (out_cnt != 3'd0);
    assign inst_sram_addr_ok = ar_hs;
    assign inst_sram_data_ok = r_acc;
    assign inst_sram_rdata   = rdata;

    assign arid     = ARID_VAL;
    assign axi_arid = ARID_VAL;
    assign arlen    = 8'h00;
    assign arburst  = 2'b01;
    assign arlock   = 2'b00;
    assign arcache  = 4'h0;
    assign arprot   = 3'b000;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Randomized bench for inst_axi_rd_bridge: a fetch requester and an AXI
// read slave around the DUT, checked against a transaction-level model.
module tb_inst_axi_rd_bridge;

    localparam int         MAX  = 2;
    localparam logic [3:0] ARID = 4'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [3:0]  axi_arid;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        err_sticky;

    always #5 clk = ~clk;

    inst_axi_rd_bridge #(
        .MAX_OUTSTANDING(MAX),
        .ARID_VAL(ARID)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inst_sram_req(inst_sram_req),
        .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .axi_arid(axi_arid),
        .arid(arid),
        .araddr(araddr),
        .arlen(arlen),
        .arsize(arsize),
        .arburst(arburst),
        .arlock(arlock),
        .arcache(arcache),
        .arprot(arprot),
        .arvalid(arvalid),
        .arready(arready),
        .rid(rid),
        .rdata(rdata),
        .rresp(rresp),
        .rlast(rlast),
        .rvalid(rvalid),
        .rready(rready),
        .err_sticky(err_sticky)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return a ^ 32'h5a5a_0f0f;
    endfunction

    // stimulus knobs, percent
    int p_req, p_ardy, p_rv, p_bad, p_err, p_wr, p_rst, p_stray;

    // reference model: one request in flight on AR, count and order of reads
    bit          m_busy;
    logic [31:0] m_addr;
    logic [1:0]  m_size;
    int          m_cnt;
    bit          m_err;
    logic [31:0] exp_q[$];
    logic [31:0] slave_q[$];
    bit          req_act;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;

    task automatic model_clear();
        m_busy  = 0;
        m_addr  = '0;
        m_size  = '0;
        m_cnt   = 0;
        m_err   = 0;
        req_act = 0;
        exp_q.delete();
        slave_q.delete();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            bit          wr_p;
            bit          hs;
            bit          acc;
            int          old_cnt;
            logic [31:0] ar_seen;
            @(negedge clk);
            reset = ($urandom_range(99) < p_rst);
            wr_p  = 0;
            if (!req_act) begin
                if ($urandom_range(99) < p_wr) begin
                    wr_p = 1;
                end else if ($urandom_range(99) < p_req) begin
                    req_act  = 1;
                    cur_addr = $urandom & 32'hffff_fffc;
                    cur_size = 2'($urandom_range(2));
                end
            end
            inst_sram_req   = req_act | wr_p;
            inst_sram_wr    = wr_p;
            inst_sram_addr  = wr_p ? $urandom : cur_addr;
            inst_sram_size  = wr_p ? 2'b10 : cur_size;
            inst_sram_wstrb = 4'($urandom);
            inst_sram_wdata = $urandom;
            arready = ($urandom_range(99) < p_ardy);
            rvalid  = 0;
            rid     = ARID;
            rdata   = $urandom;
            rresp   = 2'b00;
            if (slave_q.size() > 0 && $urandom_range(99) < p_rv) begin
                rvalid = 1;
                rdata  = fdat(slave_q[0]);
                if ($urandom_range(99) < p_bad)
                    rid = ARID ^ 4'(1 + $urandom_range(14));
                if ($urandom_range(99) < p_err)
                    rresp = 2'b10;
            end else if (slave_q.size() == 0 && $urandom_range(99) < p_stray) begin
                rvalid = 1;
                rid    = 4'($urandom);
            end
            #1;
            acc = rvalid && (m_cnt != 0) && (rid == ARID);
            chk("arvalid", 32'(arvalid), 32'(m_busy));
            chk("addr_ok", 32'(inst_sram_addr_ok), 32'(m_busy && arready));
            if (m_busy) begin
                chk("araddr", araddr, m_addr);
                chk("arsize", 32'(arsize), 32'(m_size));
            end
            chk("rready", 32'(rready), 32'(m_cnt != 0));
            chk("data_ok", 32'(inst_sram_data_ok), 32'(acc));
            if (acc && exp_q.size() > 0)
                chk("rdata", inst_sram_rdata, fdat(exp_q[0]));
            chk("err_sticky", 32'(err_sticky), 32'(m_err));
            ar_seen = araddr;
            @(posedge clk);
            hs = m_busy && arready;
            if (reset) begin
                model_clear();
            end else begin
                if (inst_sram_req && inst_sram_wr) m_err = 1;
                if (acc && rresp != 2'b00) m_err = 1;
                if (hs) begin
                    exp_q.push_back(m_addr);
                    slave_q.push_back(ar_seen);
                    req_act = 0;
                end
                if (acc) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    if (slave_q.size() > 0) void'(slave_q.pop_front());
                end
                old_cnt = m_cnt;
                m_cnt   = m_cnt + int'(hs) - int'(acc);
                if (m_busy) begin
                    if (hs) m_busy = 0;
                end else if (inst_sram_req && !inst_sram_wr && old_cnt < MAX) begin
                    m_busy = 1;
                    m_addr = inst_sram_addr;
                    m_size = inst_sram_size;
                end
            end
        end
    endtask

    task automatic knobs(input int rq, input int ar, input int rv,
                         input int bad, input int er, input int wr,
                         input int rs, input int st);
        p_req = rq; p_ardy = ar; p_rv = rv; p_bad = bad;
        p_err = er; p_wr = wr; p_rst = rs; p_stray = st;
    endtask

    initial begin
        reset = 1;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'b10;
        inst_sram_wstrb = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        chk("rst_arvalid", 32'(arvalid), 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_arsize", 32'(arsize), 32'h0);
        chk("rst_rready", 32'(rready), 32'h0);
        chk("rst_err", 32'(err_sticky), 32'h0);
        chk("rst_addr_ok", 32'(inst_sram_addr_ok), 32'h0);
        chk("arid", 32'(arid), 32'(ARID));
        chk("axi_arid", 32'(axi_arid), 32'(ARID));
        chk("arlen", 32'(arlen), 32'h0);
        chk("arburst", 32'(arburst), 32'h1);
        chk("arlock_cache_prot", 32'({arlock, arcache, arprot}), 32'h0);

        knobs(100, 100, 100, 0, 0, 0, 0, 0);   run(40);
        knobs(100, 20, 50, 0, 0, 0, 0, 0);     run(80);
        knobs(100, 100, 0, 0, 0, 0, 0, 0);     run(15);
        knobs(100, 100, 100, 0, 0, 0, 0, 0);   run(20);
        knobs(60, 60, 60, 20, 0, 0, 0, 30);    run(150);
        knobs(60, 60, 60, 20, 5, 2, 3, 30);    run(200);
        knobs(60, 60, 60, 20, 20, 5, 0, 30);   run(150);
        knobs(0, 100, 100, 0, 0, 0, 0, 0);     run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
